// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory address/data, upstream stall/redirect and the decode-facing buffer head.
interface fetch_unit_if;
    logic [31:0] pc_out;
    logic [31:0] inst_in;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        misalign_err;

    modport master (
        output pc_out,
        output out_valid,
        output out_pc,
        output out_inst,
        output misalign_err,
        input  inst_in,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  out_ready
    );

    modport slave (
        input  pc_out,
        input  out_valid,
        input  out_pc,
        input  out_inst,
        input  misalign_err,
        output inst_in,
        output stall,
        output redirect_valid,
        output redirect_target,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register plus a 2-entry {pc, inst} buffer; fetch-to-out_valid is 1 edge, redirect-to-out_valid 2 edges.
// Backpressure: a full buffer only accepts a new fetch when decode pops the head in the same cycle; stall holds the PC but lets decode drain.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master fu
);

    // PC kept as a word address so the low two bits of pc_out can never be non-zero.
    logic [29:0] r_pc_word;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_inst [2];
    logic        r_misalign;

    logic        w_pop;
    logic        w_push;
    logic        w_tail;
    logic [1:0]  w_count_nxt;
    logic [31:0] w_pc;

    assign w_pc = {r_pc_word, 2'b00};

    always_comb begin
        w_pop       = (r_count != 2'd0) && fu.out_ready;
        w_push      = !fu.redirect_valid && !fu.stall && ((r_count != 2'd2) || w_pop);
        // When full, the tail slot is the head slot being vacated by the simultaneous pop.
        w_tail      = r_head ^ r_count[0];
        w_count_nxt = r_count;
        if (fu.redirect_valid) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_word <= RESET_PC[31:2];
        end else if (fu.redirect_valid) begin
            r_pc_word <= fu.redirect_target[31:2];
        end else if (w_push) begin
            r_pc_word <= r_pc_word + 30'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (fu.redirect_valid) begin
                r_head <= 1'b0;
            end else if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]   <= 32'h0;
                r_buf_inst[i] <= 32'h0;
            end
        end else if (w_push) begin
            r_buf_pc[w_tail]   <= w_pc;
            r_buf_inst[w_tail] <= fu.inst_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (fu.redirect_valid && (fu.redirect_target[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign fu.pc_out       = w_pc;
    assign fu.out_valid    = (r_count != 2'd0);
    assign fu.out_pc       = r_buf_pc[r_head];
    assign fu.out_inst     = r_buf_inst[r_head];
    assign fu.misalign_err = r_misalign;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_out  output  32  fetch address driven to the instruction memory address input.
REQ-005 inst_in  input  32  instruction word returned combinationally by instruction memory for pc_out in the same cycle.
REQ-006 stall  input  1  upstream hold; when high, no new fetch is captured and PC holds.
REQ-007 redirect_valid  input  1  branch/jump taken; redirects fetch.
REQ-008 redirect_target  input  32  new fetch address when redirect_valid is high.
REQ-009 out_valid  output  1  buffer head holds a valid instruction for decode.
REQ-010 out_ready  input  1  decode accepts the head entry this cycle.
REQ-011 out_pc  output  32  PC of the head entry.
REQ-012 out_inst  output  32  instruction word of the head entry.
REQ-013 misalign_err  output  1  sticky flag, set by a redirect with target[1:0] != 2'b00.

Function
REQ-014 PC register drives pc_out directly; pc_out[1:0] is always 2'b00.
REQ-015 Fetch buffer is a 2-entry FIFO of {pc, inst} pairs; out_valid = (count != 0); out_pc/out_inst show the oldest entry.
REQ-016 pop = out_valid && out_ready; on pop the head entry is removed at the clock edge.
REQ-017 push = !redirect_valid && !stall && (count < 2 || pop); on push {pc_out, inst_in} is written at the tail and PC <= PC + 4.
REQ-018 Simultaneous push and pop at count 2 or count 1 leaves count unchanged; order is preserved (FIFO).
REQ-019 When no push occurs, PC holds its value.
REQ-020 PC increment is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-021 redirect_valid has priority over stall, push and pop: at the edge, count <= 0 (all entries, including head, discarded), PC <= {redirect_target[31:2], 2'b00}.
REQ-022 out_valid, out_pc and out_inst during a redirect cycle still reflect the pre-flush head; an out_ready handshake in that cycle is not counted as a delivered instruction by the block (entry is flushed).
REQ-023 First fetch at the redirected PC is pushed no earlier than the cycle after redirect_valid, i.e. redirect-to-out_valid latency is exactly 2 edges when stall is low.
REQ-024 misalign_err is set on the edge where redirect_valid is high and redirect_target[1:0] != 0; it stays set until reset.
REQ-025 Fetch latency: with an empty buffer and stall low, an instruction at pc_out is visible on out_valid/out_inst one edge later.
REQ-026 Sustained throughput: one instruction per cycle when stall low and out_ready high.
REQ-027 When stall is high with entries buffered, decode continues to drain them via pop.
REQ-028 All outputs are registered or derived only from state (no combinational path from out_ready, stall or redirect inputs to outputs).

Reset
REQ-029 While reset is high: PC = RESET_PC, count = 0, out_valid = 0, misalign_err = 0, out_pc = 0, out_inst = 0 (buffer storage cleared).
REQ-030 Reset asserted mid-operation discards all buffered entries and any in-flight redirect immediately, without waiting for a clock edge.
REQ-031 First push after reset release occurs on the first rising edge with reset low and stall low, capturing pc = RESET_PC.

Verification
REQ-032 Reset release, stall=0, out_ready=1, memory word i = 32'h1000_0000+i -> out_pc sequence 0,4,8,... one per cycle, out_inst 32'h1000_0000, 32'h1000_0001, ...
REQ-033 out_ready=0 for 5 cycles from reset -> count reaches 2, pc_out holds at 32'h8, out_pc stays 0; then out_ready=1 -> outputs pc 0,4,8 in order with no gap or duplicate.
REQ-034 Redirect to 32'h18 while buffer holds pcs 8,C -> both discarded, pc_out = 32'h18 next cycle, out_pc = 32'h18 two edges after redirect.
REQ-035 Redirect with target 32'h26 and stall=1 same cycle -> pc_out = 32'h24, misalign_err = 1 and remains 1 after further valid redirects.
REQ-036 RESET_PC = 32'hFFFF_FFF8, run 3 fetches -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Assert reset asynchronously between edges with count=2 -> out_valid falls immediately, pc_out = RESET_PC before next edge.
